// File: rtl/w_feed_ctrl.sv
// Weight feed sequencer: pops packed 32-bit words from the weight buffer and issues
// the per-precision number of w_mux reads per non-zero word, skipping all-zero words.
module w_feed_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       input_bitwidth,
  input  logic [CNT_W-1:0] num_words,
  input  logic             wbuf_valid,
  input  logic [31:0]      wbuf_data,
  output logic             wbuf_ready,
  input  logic             array_ready,
  output logic             mux_rd_en,
  output logic [31:0]      mux_data_in,
  output logic [2:0]       mux_bitwidth,
  output logic             zero_skip,
  output logic [CNT_W-1:0] skip_cnt,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] num_words_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0] word_cnt_d;
  logic [CNT_W-1:0] skip_cnt_q;
  logic [2:0]       rep_cnt_q;
  logic [2:0]       bw_q;
  logic [31:0]      data_q;
  logic             zero_skip_q;
  logic             done_q;
  logic             cfg_err_q;

  logic             bw_legal;
  logic [2:0]       reps;
  logic             last_rep;
  logic             more_words;
  logic             xfer;
  logic             word_zero;

  assign bw_legal   = (input_bitwidth == 3'b001) || (input_bitwidth == 3'b010) ||
                      (input_bitwidth == 3'b100);
  assign last_rep   = (state_q == S_ISSUE) && (rep_cnt_q == 3'd1) && array_ready;
  assign more_words = (word_cnt_q != num_words_q);
  assign word_zero  = (wbuf_data == 32'd0);
  assign word_cnt_d = word_cnt_q + 1'b1;

  always_comb begin
    reps = 3'd1;
    case (bw_q)
      3'b100:  reps = 3'd4;
      3'b010:  reps = 3'd2;
      default: reps = 3'd1;
    endcase
  end

  // Handshake: a buffer word moves on any cycle where wbuf_valid & wbuf_ready are both
  // high. wbuf_ready is raised in FETCH, and on the last rep of a word when more words
  // remain, so a word can follow the previous one with no bubble.
  assign wbuf_ready = !RST && ((state_q == S_FETCH) || (last_rep && more_words));
  assign mux_rd_en  = !RST && (state_q == S_ISSUE) && array_ready;
  assign xfer       = wbuf_ready && wbuf_valid;

  assign mux_data_in  = data_q;
  assign mux_bitwidth = bw_q;
  assign zero_skip    = zero_skip_q;
  assign skip_cnt     = skip_cnt_q;
  assign busy         = (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign dbg_state    = state_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= S_IDLE;
      num_words_q <= '0;
      word_cnt_q  <= '0;
      skip_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      bw_q        <= '0;
      data_q      <= '0;
      zero_skip_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      zero_skip_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (bw_legal) begin
              bw_q        <= input_bitwidth;
              num_words_q <= num_words;
              word_cnt_q  <= '0;
              skip_cnt_q  <= '0;
              state_q     <= (num_words == '0) ? S_DONE : S_FETCH;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
        end
        S_ISSUE: begin
          // A stalled array freezes rep_cnt and data, which freezes the w_mux pointer.
          if (mux_rd_en) rep_cnt_q <= rep_cnt_q - 3'd1;
          if (last_rep) state_q <= more_words ? S_FETCH : S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Word consumption is shared by FETCH and the back-to-back fetch in ISSUE.
      if (xfer) begin
        word_cnt_q <= word_cnt_d;
        if (word_zero) begin
          zero_skip_q <= 1'b1;
          skip_cnt_q  <= skip_cnt_q + 1'b1;
          state_q     <= (word_cnt_d == num_words_q) ? S_DONE : S_FETCH;
        end else begin
          data_q    <= wbuf_data;
          rep_cnt_q <= reps;
          state_q   <= S_ISSUE;
        end
      end
    end
  end

endmodule
